bit_serial_subtractor: RTL

BIT_SERIAL_SUBTRACTOR -- requirements
Module: bit_serial_subtractor

---
 rtl/bit_serial_subtractor.sv | 134 +++++++++++++
 1 files changed

// File: rtl/bit_serial_subtractor.sv
// rtl/bit_serial_subtractor.sv - LSB-first bit-serial a - b - bin with valid/ready handshakes
// Optional BIT_SERIAL_SUBTRACTOR_OVF_EN adds a signed overflow output (ovf).
module bit_serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
`ifdef BIT_SERIAL_SUBTRACTOR_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-2:0] r_res;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;
`ifdef BIT_SERIAL_SUBTRACTOR_OVF_EN
    logic             r_ovf;
`endif

    logic             w_a0;
    logic             w_b0;
    logic             w_d;
    logic             w_br_next;
    logic             w_last;
    logic [WIDTH-1:0] w_cat;

    assign w_a0      = r_a[0];
    assign w_b0      = r_b[0];
    assign w_d       = w_a0 ^ w_b0 ^ r_br;
    assign w_br_next = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_br);
    assign w_last    = (r_cnt == CW'(WIDTH - 1));
    // On the last RUN cycle w_cat holds the complete difference, MSB = current bit.
    assign w_cat     = {w_d, r_res};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_res       <= '0;
            r_br        <= 1'b0;
            r_cnt       <= '0;
            r_diff      <= '0;
            r_bout      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
`ifdef BIT_SERIAL_SUBTRACTOR_OVF_EN
            r_ovf       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_br       <= bin;
                        r_cnt      <= '0;
                        r_state    <= S_RUN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_res <= w_cat[WIDTH-1:1];
                    r_br  <= w_br_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_diff      <= w_cat;
                        r_bout      <= w_br_next;
`ifdef BIT_SERIAL_SUBTRACTOR_OVF_EN
                        // Operand MSBs are in bit 0 of the shifters on the final cycle.
                        r_ovf       <= (w_a0 ^ w_b0) & (w_d ^ w_a0);
`endif
                        r_state     <= S_DONE;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign diff      = r_diff;
    assign bout      = r_bout;
`ifdef BIT_SERIAL_SUBTRACTOR_OVF_EN
    assign ovf       = r_ovf;
`endif

endmodule
